// File: rtl/avalon_frame_writer.sv
// Turns a 24-bit SOP/EOP pixel stream into 32-bit writes, one word per pixel.
// Also checks framing: short, long and restarted frames set a sticky error flag.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a beat with sop; beats without sop are dropped
//   RECV  | inside a frame; each beat is written to the next pixel slot
//   DROP  | long frame overflowed; beats are discarded until eop or sop
module avalon_frame_writer #(
    parameter int          N         = 640,
    parameter int          M         = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Enable,
    input  logic [23:0] Sink_data,
    input  logic        Sink_valid,
    input  logic        Sink_sop,
    input  logic        Sink_eop,
    output logic        Sink_ready,
    output logic [31:0] Wr_address,
    output logic [31:0] Wr_writedata,
    output logic        Wr_write,
    input  logic        Wr_waitrequest,
    output logic        Frame_done,
    output logic [15:0] Frame_count,
    output logic        Err_flag,
    input  logic        Err_clear
);

    localparam int FRAME_PIXELS = M * N;
    localparam int CW           = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt, idx;
    logic          accept, wr_accept, wr_load, good_end, err_set;
    logic          wr_last;

    assign Sink_ready = Enable && (!Wr_write || !Wr_waitrequest);
    assign accept     = Sink_valid && Sink_ready;
    assign wr_accept  = Wr_write && !Wr_waitrequest;
    // wr_last tags the pending write as the final pixel of a good frame
    assign Frame_done = wr_accept && wr_last;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_load   = 1'b0;
        good_end  = 1'b0;
        err_set   = 1'b0;
        // sop always restarts at pixel 0, whatever state we are in
        idx       = Sink_sop ? '0 : count;
        if (accept) begin
            if (Sink_sop || state == RECV) begin
                wr_load = 1'b1;
                if (Sink_sop && state == RECV)
                    err_set = 1'b1;
                if (Sink_eop) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    if (idx == LAST_IDX)
                        good_end = 1'b1;
                    else
                        err_set = 1'b1;
                end else if (idx == LAST_IDX) begin
                    state_nxt = DROP;
                    count_nxt = '0;
                    err_set   = 1'b1;
                end else begin
                    state_nxt = RECV;
                    count_nxt = idx + CW'(1);
                end
            end else if (state == DROP && Sink_eop) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Wr_write     <= 1'b0;
            Wr_address   <= BASE_ADDR;
            Wr_writedata <= '0;
            wr_last      <= 1'b0;
        end else if (wr_load) begin
            Wr_write     <= 1'b1;
            Wr_address   <= BASE_ADDR + (32'(idx) << 2);
            Wr_writedata <= {8'h00, Sink_data};
            wr_last      <= good_end;
        end else if (wr_accept) begin
            Wr_write     <= 1'b0;
            wr_last      <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Frame_count <= '0;
            Err_flag    <= 1'b0;
        end else begin
            if (Frame_done)
                Frame_count <= Frame_count + 16'd1;
            if (err_set)
                Err_flag <= 1'b1;
            else if (Err_clear)
                Err_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_avalon_frame_writer.sv
// Scoreboard bench for avalon_frame_writer with a 4x2 frame: expected writes
// are queued as beats are accepted and popped as the memory side takes them.
module tb_avalon_frame_writer;

    localparam int          N    = 4;
    localparam int          M    = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset_n, Enable, Sink_valid, Sink_sop, Sink_eop;
    logic [23:0] Sink_data;
    logic        Sink_ready, Wr_write, Wr_waitrequest, Frame_done, Err_flag, Err_clear;
    logic [31:0] Wr_address, Wr_writedata;
    logic [15:0] Frame_count;

    avalon_frame_writer #(.N(N), .M(M), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable),
        .Sink_data(Sink_data), .Sink_valid(Sink_valid), .Sink_sop(Sink_sop),
        .Sink_eop(Sink_eop), .Sink_ready(Sink_ready),
        .Wr_address(Wr_address), .Wr_writedata(Wr_writedata), .Wr_write(Wr_write),
        .Wr_waitrequest(Wr_waitrequest), .Frame_done(Frame_done),
        .Frame_count(Frame_count), .Err_flag(Err_flag), .Err_clear(Err_clear)
    );

    always #5 Clk = ~Clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_seen = 0;
    int          exp_done = 0;
    logic [15:0] exp_fc = 0;
    logic        stall_arm = 1'b0;
    logic [63:0] exp_q[$];
    logic [23:0] px[0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic new_pixels();
        for (int i = 0; i < 16; i++) px[i] = 24'($urandom);
    endtask

    // One beat; returns at posedge+1 of the accepting edge.
    task automatic send_beat(input logic [23:0] pix, input logic sop, input logic eop,
                             input logic exp_wr, input int idx);
        Sink_data  = pix;
        Sink_sop   = sop;
        Sink_eop   = eop;
        Sink_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge Clk);
            if (Sink_ready) break;
            if (t > 50) begin
                chk("ready_timeout", 32'(Sink_ready), 1);
                Sink_valid = 1'b0;
                return;
            end
        end
        @(posedge Clk);
        if (exp_wr) exp_q.push_back({BASE + 32'(idx * 4), 8'h00, pix});
        #1;
        Sink_valid = 1'b0;
        Sink_sop   = 1'b0;
        Sink_eop   = 1'b0;
    endtask

    task automatic drain(input logic exp_err);
        int t;
        for (t = 0; t < 60; t++) begin
            @(posedge Clk);
            #2;
            if (exp_q.size() == 0 && !Wr_write) break;
        end
        chk("drain_q_empty", 32'(exp_q.size()), 0);
        chk("drain_wr_idle", 32'(Wr_write), 0);
        chk("frame_count", 32'(Frame_count), 32'(exp_fc));
        chk("frame_done_cnt", 32'(done_seen), 32'(exp_done));
        chk("err_flag", 32'(Err_flag), 32'(exp_err));
    endtask

    task automatic clear_err();
        @(posedge Clk); #1 Err_clear = 1'b1;
        @(posedge Clk); #1 Err_clear = 1'b0;
        chk("err_cleared", 32'(Err_flag), 0);
    endtask

    task automatic good_frame();
        new_pixels();
        for (int i = 0; i < 8; i++) send_beat(px[i], i == 0, i == 7, 1'b1, i);
        exp_fc++;
        exp_done++;
        drain(1'b0);
    endtask

    // Memory side: pops expected writes as they are accepted.
    initial forever begin
        @(negedge Clk);
        if (Frame_done) done_seen++;
        if (Wr_write && !Wr_waitrequest) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'(exp_q.size()), 1);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_address", Wr_address, e[63:32]);
                chk("wr_writedata", Wr_writedata, e[31:0]);
            end
        end
    end

    // Three-cycle stall on the write of pixel 2 when armed.
    initial forever begin
        @(posedge Clk);
        #1;
        if (stall_arm && Wr_write && Wr_address == BASE + 32'h8) begin
            stall_arm      = 1'b0;
            Wr_waitrequest = 1'b1;
            repeat (3) begin
                @(negedge Clk);
                chk("stall_ready", 32'(Sink_ready), 0);
                chk("stall_write", 32'(Wr_write), 1);
                chk("stall_addr", Wr_address, BASE + 32'h8);
                chk("stall_data", Wr_writedata, {8'h00, px[2]});
            end
            @(posedge Clk);
            #1 Wr_waitrequest = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; Enable = 1'b0; Sink_valid = 1'b0; Sink_sop = 1'b0;
        Sink_eop = 1'b0; Sink_data = '0; Wr_waitrequest = 1'b0; Err_clear = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_wr_write", 32'(Wr_write), 0);
        chk("rst_wr_address", Wr_address, BASE);
        chk("rst_wr_data", Wr_writedata, 0);
        chk("rst_frame_count", 32'(Frame_count), 0);
        chk("rst_err", 32'(Err_flag), 0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("ready_disabled", 32'(Sink_ready), 0);
        Enable = 1'b1;
        #1 chk("ready_enabled", 32'(Sink_ready), 1);

        // Good frame with an Enable pause mid-frame
        new_pixels();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                Enable = 1'b0;
                repeat (3) begin
                    @(negedge Clk);
                    chk("pause_ready", 32'(Sink_ready), 0);
                end
                @(posedge Clk); #1 Enable = 1'b1;
            end
            send_beat(px[i], i == 0, i == 7, 1'b1, i);
        end
        exp_fc++; exp_done++;
        drain(1'b0);

        // Backpressure on pixel 2
        new_pixels();
        stall_arm = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(px[i], i == 0, i == 7, 1'b1, i);
        exp_fc++; exp_done++;
        drain(1'b0);
        chk("stall_consumed", 32'(stall_arm), 0);

        // Short frame; Err_clear coincides with the error and must lose
        new_pixels();
        for (int i = 0; i < 4; i++) send_beat(px[i], i == 0, 1'b0, 1'b1, i);
        Err_clear = 1'b1;
        send_beat(px[4], 1'b0, 1'b1, 1'b1, 4);
        Err_clear = 1'b0;
        chk("err_beats_clear", 32'(Err_flag), 1);
        drain(1'b1);
        clear_err();
        good_frame();

        // Long frame: beats 8..10 dropped
        new_pixels();
        for (int i = 0; i < 11; i++) send_beat(px[i], i == 0, i == 10, i < 8, i);
        drain(1'b1);
        clear_err();

        // Garbage before sop, then a restarted frame
        new_pixels();
        send_beat(px[0], 1'b0, 1'b0, 1'b0, 0);
        send_beat(px[1], 1'b0, 1'b0, 1'b0, 0);
        chk("garbage_no_err", 32'(Err_flag), 0);
        for (int i = 0; i < 3; i++) send_beat(px[2 + i], i == 0, 1'b0, 1'b1, i);
        for (int i = 0; i < 8; i++) send_beat(px[5 + i], i == 0, i == 7, 1'b1, i);
        exp_fc++; exp_done++;
        drain(1'b1);

        // Reset while pixel 5 is on offer
        new_pixels();
        for (int i = 0; i < 5; i++) send_beat(px[i], i == 0, 1'b0, 1'b1, i);
        Sink_data = px[5]; Sink_valid = 1'b1;
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        chk("arst_wr_write", 32'(Wr_write), 0);
        chk("arst_wr_address", Wr_address, BASE);
        chk("arst_wr_data", Wr_writedata, 0);
        chk("arst_frame_done", 32'(Frame_done), 0);
        chk("arst_frame_count", 32'(Frame_count), 0);
        chk("arst_err", 32'(Err_flag), 0);
        chk("arst_q_empty", 32'(exp_q.size()), 0);
        Sink_valid = 1'b0;
        exp_fc = 0;
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        good_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
